// File: rtl/memory_port_arbiter_pkg.sv
// Shared encodings for the unified memory port arbiter.
package memory_port_arbiter_pkg;

  localparam int ARB_XLEN  = 32;
  localparam int ARB_CNT_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'b00,
    ARB_REQ  = 2'b01,
    ARB_RESP = 2'b10,
    ARB_DONE = 2'b11
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/bus_timeout_counter.sv
// Counts cycles a bus transaction has been outstanding; flags the last allowed cycle.
module bus_timeout_counter
  import memory_port_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  // expired fires during the TIMEOUT-th enabled cycle, so the owner leaves REQ/RESP
  // after spending exactly TIMEOUT cycles there.
  localparam logic [ARB_CNT_W-1:0] LAST = ARB_CNT_W'(TIMEOUT - 1);

  logic [ARB_CNT_W-1:0] cnt_q, cnt_d;

  // next count: clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)       cnt_d = '0;
    else if (enable_i) cnt_d = cnt_q + ARB_CNT_W'(1);
  end

  // count register
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/memory_port_arbiter.sv
// Shares one memory bus between instruction fetch and load/store, stalling the
// requesting phase until its transaction finishes; aborts stuck transactions.
module memory_port_arbiter
  import memory_port_arbiter_pkg::*;
#(
  parameter int XLEN    = ARB_XLEN,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            phase_fetch,
  input  logic            phase_memoryaccess,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            stall_fetch,
  input  logic            dm_req,
  input  logic            dm_we,
  input  logic [3:0]      dm_wstrb,
  input  logic [XLEN-1:0] dm_addr,
  input  logic [XLEN-1:0] dm_wdata,
  output logic [XLEN-1:0] dm_rdata,
  output logic            stall_memoryaccess,
  output logic            mem_req,
  output logic            mem_we,
  output logic [3:0]      mem_wstrb,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            bus_err
);

  arb_state_e      state_q, state_d;
  arb_owner_e      owner_q, owner_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [3:0]      mem_wstrb_q, mem_wstrb_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic [XLEN-1:0] dm_rdata_q, dm_rdata_d;
  logic            bus_err_q, bus_err_d;
  logic            if_act, dm_act, tmo_en, tmo_clr, tmo_expired;

  assign if_act  = phase_fetch & if_req;
  assign dm_act  = phase_memoryaccess & dm_req;
  assign tmo_en  = (state_q == ARB_REQ) || (state_q == ARB_RESP);
  assign tmo_clr = (state_q == ARB_IDLE);

  bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (tmo_clr),
    .enable_i  (tmo_en),
    .expired_o (tmo_expired)
  );

  // next-state, bus command latch and read-data capture
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    bus_err_d   = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        // data side wins a same-cycle collision
        if (dm_act) begin
          owner_d     = OWN_DM;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_we;
          mem_wstrb_d = dm_wstrb;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = ARB_REQ;
        end else if (if_act) begin
          owner_d     = OWN_IF;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_wstrb_d = '0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          state_d     = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_we_q ? ARB_DONE : ARB_RESP;
        end
      end
      ARB_RESP: begin
        if (mem_rvalid) begin
          state_d = ARB_DONE;
          // a requester that walked away mid-transaction gets nothing
          if (owner_q == OWN_DM) begin
            if (dm_act) dm_rdata_d = mem_rdata;
          end else begin
            if (if_act) if_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    // timeout overrides any completion seen in the same cycle
    if (tmo_expired) begin
      state_d   = ARB_DONE;
      mem_req_d = 1'b0;
      bus_err_d = 1'b1;
      if (owner_q == OWN_DM) dm_rdata_d = '0;
      else                   if_rdata_d = '0;
    end
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_IF;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign stall_fetch        = if_act & ~((state_q == ARB_DONE) & (owner_q == OWN_IF));
  assign stall_memoryaccess = dm_act & ~((state_q == ARB_DONE) & (owner_q == OWN_DM));

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Self-checking bench for memory_port_arbiter: vector table plus corner-case sequences.
module tb_memory_port_arbiter;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        phase_fetch, phase_memoryaccess, if_req, dm_req, dm_we;
  logic [31:0] if_addr, dm_addr, dm_wdata;
  logic [3:0]  dm_wstrb;
  logic [31:0] if_rdata, dm_rdata;
  logic        stall_fetch, stall_memoryaccess;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid, bus_err;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  memory_port_arbiter #(.XLEN(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .phase_fetch(phase_fetch), .phase_memoryaccess(phase_memoryaccess),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .stall_fetch(stall_fetch),
    .dm_req(dm_req), .dm_we(dm_we), .dm_wstrb(dm_wstrb), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .stall_memoryaccess(stall_memoryaccess),
    .mem_req(mem_req), .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic        dm;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          g;          // REQ cycles before gnt; -1 = never
    int          r;          // cycles from gnt to rvalid; 0 = never
    int          exp_stall;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          stalls;
  } exp_t;

  exp_t        sb[$];
  vec_t        tbl[10];
  int          n_cmp = 0, n_bad = 0;
  int          gnt_dly = 0, rv_dly = 1;
  int          gnt_total = 0, fld_bad_total = 0;
  logic [31:0] last_dm = '0;
  logic        snap_we;
  logic [3:0]  snap_wstrb;
  logic [31:0] snap_addr, snap_wdata;

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return (a == 32'h0) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
  endfunction

  function automatic vec_t mk(input logic dm, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] wstrb,
                              input int g, input int r, input int st, input logic err);
    vec_t v;
    v.dm = dm; v.we = we; v.addr = addr; v.wdata = wdata; v.wstrb = wstrb;
    v.g = g; v.r = r; v.exp_stall = st; v.exp_err = err;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // bus slave: grants after gnt_dly REQ cycles, returns read data rv_dly cycles later
  initial begin
    int          req_seen;
    int          rv_left;
    logic [31:0] rv_data;
    req_seen = 0; rv_left = 0; rv_data = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    forever begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'hBAD0_BAD0;
      if (rv_left > 0) begin
        rv_left--;
        if (rv_left == 0) begin mem_rvalid = 1'b1; mem_rdata = rv_data; end
      end
      if (mem_req) begin
        if (req_seen == 0) begin
          snap_we = mem_we; snap_wstrb = mem_wstrb; snap_addr = mem_addr; snap_wdata = mem_wdata;
        end else if ({mem_we, mem_wstrb, mem_addr, mem_wdata} !==
                     {snap_we, snap_wstrb, snap_addr, snap_wdata}) begin
          fld_bad_total++;
        end
        if (gnt_dly >= 0 && req_seen == gnt_dly) begin
          mem_gnt = 1'b1;
          gnt_total++;
          if (!mem_we && rv_dly > 0) begin rv_left = rv_dly; rv_data = rd_model(mem_addr); end
        end
        req_seen++;
      end else begin
        req_seen = 0;
      end
    end
  end

  // one transaction from request to DONE, then one extra held cycle to prove DONE is single
  task automatic run_txn(input vec_t v);
    exp_t        e, o;
    int          stalls, cyc, g0, f0;
    logic        fin, act_err;
    logic [31:0] act_rd;
    stalls = 0; cyc = 0; fin = 1'b0;
    gnt_dly = v.g; rv_dly = v.r; g0 = gnt_total; f0 = fld_bad_total;
    e.err = v.exp_err; e.stalls = v.exp_stall;
    if (v.exp_err)  e.rd = '0;
    else if (v.we)  e.rd = last_dm;
    else            e.rd = rd_model(v.addr);
    if (v.dm) last_dm = e.rd;
    sb.push_back(e);
    if (v.dm) begin
      phase_memoryaccess = 1'b1; dm_req = 1'b1; dm_we = v.we;
      dm_addr = v.addr; dm_wdata = v.wdata; dm_wstrb = v.wstrb;
    end else begin
      phase_fetch = 1'b1; if_req = 1'b1; if_addr = v.addr;
    end
    while (!fin && cyc < 40) begin
      #1;
      if (v.dm ? stall_memoryaccess : stall_fetch) begin
        stalls++; @(negedge clk); cyc++;
      end else fin = 1'b1;
    end
    act_rd  = v.dm ? dm_rdata : if_rdata;
    act_err = bus_err;
    chk("txn_completes", fin, 1);
    o = sb.pop_front();
    chk("stall_cycles", stalls, o.stalls);
    chk("rdata", act_rd, o.rd);
    chk("bus_err_done", act_err, o.err);
    @(negedge clk); #1;
    chk("done_one_cycle", v.dm ? stall_memoryaccess : stall_fetch, 1);
    chk("bus_err_pulse", bus_err, 0);
    phase_fetch = 1'b0; if_req = 1'b0; phase_memoryaccess = 1'b0; dm_req = 1'b0;
    chk("gnt_count", gnt_total - g0, (v.g >= 0) ? 1 : 0);
    chk("fields_stable", fld_bad_total - f0, 0);
    chk("req_addr", snap_addr, v.addr);
    chk("req_we", snap_we, v.we);
    if (v.we) begin
      chk("req_wdata", snap_wdata, v.wdata);
      chk("req_wstrb", snap_wstrb, v.wstrb);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got %0d cmp expected done", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   cyc, sf, g0;
    exp_t e, o;
    vec_t v;

    //          dm  we  addr          wdata         wstrb    g   r  stall err
    tbl[0] = mk(0, 0, 32'h0000_0000, 32'h0,        4'b0000,  0, 1, 3,    0);
    tbl[1] = mk(1, 1, 32'h0000_0100, 32'hDEADBEEF, 4'b0011,  2, 0, 4,    0);
    tbl[2] = mk(1, 0, 32'h0000_0200, 32'h0,        4'b0000,  1, 1, 4,    0);
    tbl[3] = mk(1, 0, 32'h0000_0300, 32'h0,        4'b0000,  0, 0, 1+TO, 1);
    tbl[4] = mk(0, 0, 32'h0000_0004, 32'h0,        4'b0000,  0, 2, 4,    0);
    tbl[5] = mk(1, 1, 32'h0000_0104, 32'h1111_2222, 4'b1100, -1, 0, 1+TO, 1);
    tbl[6] = mk(1, 0, 32'h0000_0204, 32'h0,        4'b0000,  0, 1, 3,    0);
    tbl[7] = mk(0, 0, 32'h0000_0008, 32'h0,        4'b0000,  1, 0, 1+TO, 1);
    tbl[8] = mk(1, 1, 32'h0000_0108, 32'h1234_5678, 4'b1111,  0, 0, 2,    0);
    tbl[9] = mk(0, 0, 32'h0000_000C, 32'h0,        4'b0000,  0, 1, 3,    0);

    rst = 1'b1;
    phase_fetch = 1'b0; phase_memoryaccess = 1'b0; if_req = 1'b0; dm_req = 1'b0;
    dm_we = 1'b0; dm_wstrb = '0; if_addr = '0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_if_rdata", if_rdata, 0);
    chk("rst_dm_rdata", dm_rdata, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall_fetch", stall_fetch, 0);
    chk("rst_stall_mem", stall_memoryaccess, 0);
    phase_fetch = 1'b1; if_req = 1'b1;
    #1;
    chk("rst_stall_with_req", stall_fetch, 1);
    phase_fetch = 1'b0; if_req = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 10; i++) run_txn(tbl[i]);

    // simultaneous requests: data side first, fetch stalls through it and its own transaction
    gnt_dly = 0; rv_dly = 1; g0 = gnt_total; cyc = 0; sf = 0;
    e.err = 1'b0; e.stalls = 3; e.rd = rd_model(32'h210); sb.push_back(e);
    e.stalls = 7; e.rd = rd_model(32'h10); sb.push_back(e);
    last_dm = rd_model(32'h210);
    phase_fetch = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    phase_memoryaccess = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h210;
    #1;
    while (stall_memoryaccess && cyc < 40) begin
      if (stall_fetch) sf++;
      @(negedge clk); #1; cyc++;
    end
    o = sb.pop_front();
    chk("both_dm_stalls", cyc, o.stalls);
    chk("both_dm_rdata", dm_rdata, o.rd);
    chk("both_fetch_held", stall_fetch, 1);
    chk("both_dm_gnts", gnt_total - g0, 1);
    if (stall_fetch) sf++;
    phase_memoryaccess = 1'b0; dm_req = 1'b0;
    while (stall_fetch && cyc < 40) begin
      @(negedge clk); #1; cyc++;
      if (stall_fetch) sf++;
    end
    o = sb.pop_front();
    chk("both_fetch_stalls", sf, o.stalls);
    chk("both_if_rdata", if_rdata, o.rd);
    chk("both_gnts", gnt_total - g0, 2);
    phase_fetch = 1'b0; if_req = 1'b0;
    @(negedge clk);

    // back-to-back fetches with idle phases in between
    g0 = gnt_total;
    for (int i = 0; i < 3; i++) begin
      v = mk(0, 0, 32'h40 + 32'(i * 4), 32'h0, 4'b0000, 0, 1, 3, 0);
      run_txn(v);
      repeat (3) begin
        #1; chk("loop_idle_no_req", mem_req, 0);
        @(negedge clk);
      end
    end
    chk("loop_gnt_pairs", gnt_total - g0, 3);

    // reset during RESP; read data arrives after reset is released
    gnt_dly = 0; rv_dly = 3;
    phase_fetch = 1'b1; if_req = 1'b1; if_addr = 32'h20;
    @(negedge clk);
    @(negedge clk);
    #1; chk("resp_req_dropped", mem_req, 0);
    rst = 1'b1; phase_fetch = 1'b0; if_req = 1'b0;
    @(negedge clk); #1;
    chk("midrst_mem_req", mem_req, 0);
    chk("midrst_if_rdata", if_rdata, 0);
    chk("midrst_dm_rdata", dm_rdata, 0);
    chk("midrst_stall", stall_fetch, 0);
    rst = 1'b0; last_dm = '0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("late_rvalid_ignored", if_rdata, 0);
    chk("late_rvalid_no_req", mem_req, 0);
    chk("late_rvalid_no_err", bus_err, 0);
    @(negedge clk);

    // the arbiter must be idle and usable after reset
    run_txn(mk(1, 0, 32'h0000_0280, 32'h0, 4'b0000, 0, 1, 3, 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
